fence_unit: RTL and testbench

- Sequencer that executes FENCE, FENCE.TSO and FENCE.I in the core's execute stage.
- It classifies the instruction from funct3, fm, pred and succ. It then waits until the selected memory ports and the store buffer have drained.
- For FENCE.I it also runs an I-cache flush handshake and requests a pipeline flush.
- It is the sequential successor of the fence decoder. It adds kinds, pred/succ handling, a configurable port count and a timeout.

---
 rtl/fence_unit_pkg.sv | 29 ++
 rtl/fence_unit_if.sv | 33 +++
 rtl/fence_unit_classify.sv | 41 ++++
 rtl/fence_unit.sv | 104 ++++++++++
 tb/tb_fence_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fence_unit_pkg.sv
// Shared fence types: instruction kinds, sequencer states and fence field encodings.
package fence_unit_pkg;

    typedef enum logic [2:0] {
        fk_fence     = 3'd0,
        fk_fence_i   = 3'd1,
        fk_invalid   = 3'd2,
        fk_fence_tso = 3'd3,
        fk_nop       = 3'd4
    } fence_kind_t;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_DRAIN   = 2'd1,
        FS_ICFLUSH = 2'd2,
        FS_DONE    = 2'd3
    } fence_state_t;

    localparam logic [2:0] F3_FENCE     = 3'b000;
    localparam logic [2:0] F3_FENCE_I   = 3'b001;
    localparam logic [3:0] FENCE_FM_TSO = 4'b1000;

    // Bit positions inside pred/succ: {I,O,R,W}
    localparam int PW = 0;
    localparam int PR = 1;
    localparam int PO = 2;
    localparam int PI = 3;

endpackage

// File: rtl/fence_unit_if.sv
// Execute-stage <-> fence sequencer bundle, including memory/store-buffer/I-cache status.
interface fence_unit_if #(
    parameter int NUM_PORTS = 2
);
    import fence_unit_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           funct3;
    logic [3:0]           fm;
    logic [3:0]           pred;
    logic [3:0]           succ;
    logic [NUM_PORTS-1:0] mem_pending;
    logic                 sb_empty;
    logic                 sb_drain;
    logic                 ic_flush_req;
    logic                 ic_flush_ack;
    logic                 pipe_flush;
    logic                 done_valid;
    fence_kind_t          done_kind;
    logic                 timeout_err;

    modport slave (
        input  req_valid, funct3, fm, pred, succ, mem_pending, sb_empty, ic_flush_ack,
        output req_ready, sb_drain, ic_flush_req, pipe_flush, done_valid, done_kind, timeout_err
    );

    modport master (
        output req_valid, funct3, fm, pred, succ, mem_pending, sb_empty, ic_flush_ack,
        input  req_ready, sb_drain, ic_flush_req, pipe_flush, done_valid, done_kind, timeout_err
    );

endinterface

// File: rtl/fence_unit_classify.sv
// Combinational fence decode: kind plus which resources the fence has to wait on.
module fence_classify
    import fence_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [3:0]  fm,
    input  logic [3:0]  pred,
    input  logic [3:0]  succ,
    output fence_kind_t kind,
    output logic        wait_mem,
    output logic        wait_io,
    output logic        wait_sb
);

    always_comb begin
        kind     = fk_invalid;
        wait_mem = 1'b0;
        wait_io  = 1'b0;
        wait_sb  = 1'b0;
        if (funct3 == F3_FENCE_I) begin
            kind     = fk_fence_i;
            wait_mem = 1'b1;
            wait_io  = 1'b1;
            wait_sb  = 1'b1;
        end else if (funct3 == F3_FENCE) begin
            if (fm == FENCE_FM_TSO && pred == 4'b0011 && succ == 4'b0011)
                kind = fk_fence_tso;
            else if (pred == 4'b0000 || succ == 4'b0000)
                kind = fk_nop;
            else
                kind = fk_fence;
            if (kind != fk_nop) begin
                wait_mem = pred[PR] | pred[PW];
                wait_io  = pred[PI] | pred[PO];
                // TSO leaves W->R unordered, so buffered stores may stay put
                wait_sb  = pred[PW] && (kind != fk_fence_tso);
            end
        end
    end

endmodule

// File: rtl/fence_unit.sv
// Fence sequencer: drains selected ports / store buffer, runs the FENCE.I I-cache flush.
module fence_unit
    import fence_unit_pkg::*;
#(
    parameter int                   NUM_PORTS    = 2,
    parameter logic [NUM_PORTS-1:0] IO_PORT_MASK = 2'b10,
    parameter int                   TIMEOUT      = 255
)(
    input  logic         clk,
    input  logic         rst,
    fence_unit_if.slave  fif
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    localparam logic [1:0] S_IDLE    = FS_IDLE;
    localparam logic [1:0] S_DRAIN   = FS_DRAIN;
    localparam logic [1:0] S_ICFLUSH = FS_ICFLUSH;
    localparam logic [1:0] S_DONE    = FS_DONE;

    logic [1:0]           state;
    fence_kind_t          kind_q;
    logic [NUM_PORTS-1:0] mask_q;
    logic                 wsb_q;
    logic [TW-1:0]        timer;
    logic                 err_q;

    fence_kind_t          c_kind;
    logic                 c_wait_mem, c_wait_io, c_wait_sb;
    logic [NUM_PORTS-1:0] c_mask;
    logic                 drained, tmo;
    logic [TW-1:0]        timer_inc;

    fence_classify u_classify (
        .funct3   (fif.funct3),
        .fm       (fif.fm),
        .pred     (fif.pred),
        .succ     (fif.succ),
        .kind     (c_kind),
        .wait_mem (c_wait_mem),
        .wait_io  (c_wait_io),
        .wait_sb  (c_wait_sb)
    );

    assign c_mask    = (c_wait_mem ? ~IO_PORT_MASK : '0) | (c_wait_io ? IO_PORT_MASK : '0);
    assign drained   = ((fif.mem_pending & mask_q) == '0) && (fif.sb_empty || !wsb_q);
    // Fires on the TIMEOUT-th cycle spent in the current wait state
    assign tmo       = (timer >= TW'(TIMEOUT - 1));
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            kind_q <= fk_fence;
            mask_q <= '0;
            wsb_q  <= 1'b0;
            timer  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (fif.req_valid) begin
                    kind_q <= c_kind;
                    mask_q <= c_mask;
                    wsb_q  <= c_wait_sb;
                    timer  <= '0;
                    state  <= (c_kind == fk_nop || c_kind == fk_invalid) ? S_DONE : S_DRAIN;
                end
                S_DRAIN: begin
                    // A drain that completes on the timeout cycle is a normal exit
                    if (drained) begin
                        timer <= '0;
                        state <= (kind_q == fk_fence_i) ? S_ICFLUSH : S_DONE;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_ICFLUSH: begin
                    if (fif.ic_flush_ack) begin
                        state <= S_DONE;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fif.req_ready    = (state == S_IDLE);
    assign fif.sb_drain     = (state == S_DRAIN) && wsb_q && !fif.sb_empty;
    assign fif.ic_flush_req = (state == S_ICFLUSH);
    assign fif.done_valid   = (state == S_DONE);
    assign fif.done_kind    = (state == S_DONE) ? kind_q : fk_fence;
    assign fif.pipe_flush   = (state == S_DONE) && (kind_q == fk_fence_i);
    assign fif.timeout_err  = err_q;

endmodule

// File: tb/tb_fence_unit.sv
// Bench for fence_unit: directed vector table, reset corner case, randomized fences vs. a reference model.
module tb_fence_unit;
    import fence_unit_pkg::*;

    localparam int             NP   = 2;
    localparam logic [NP-1:0]  IOM  = 2'b10;
    localparam int             TMO  = 8;
    localparam int             MAXC = 40;
    localparam int             NVEC = 18;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fence_unit_if #(.NUM_PORTS(NP)) fif ();

    fence_unit #(.NUM_PORTS(NP), .IO_PORT_MASK(IOM), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus; index c = c-th cycle after the accept edge
    logic [NP-1:0] mp [0:MAXC];
    logic          se [0:MAXC];
    logic          ak [0:MAXC];
    bit            mdl_err;

    typedef struct {
        int lat, nsb, nicf, kind, pf, err, rdy_bad;
    } obs_t;

    typedef struct {
        logic [2:0]  f3;
        logic [3:0]  fm, pred, succ;
        logic [1:0]  mpv;
        int          mpn, sbn, ackc;
        fence_kind_t kind;
        int          lat, nsb, nicf, pf, err;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [1:0] mpv, input int mpn, input int sbn, input int ackc);
        for (int c = 0; c <= MAXC; c++) begin
            mp[c] = (c <= mpn) ? mpv : '0;
            se[c] = (c > sbn);
            ak[c] = (c == ackc);
        end
    endtask

    task automatic set_idle();
        fif.req_valid    = 1'b0;
        fif.mem_pending  = '0;
        fif.sb_empty     = 1'b1;
        fif.ic_flush_ack = 1'b0;
    endtask

    // Issue one fence at the next IDLE cycle and observe it until done_valid
    task automatic run(input string nm, input logic [2:0] f3, input logic [3:0] fmv,
                       input logic [3:0] pv, input logic [3:0] sv, output obs_t o);
        o = '{default: 0};
        o.lat = -1;
        @(posedge clk); #1;
        chk({nm, "_ready"}, int'(fif.req_ready), 1);
        chk({nm, "_nodone"}, int'(fif.done_valid), 0);
        fif.req_valid = 1'b1;
        fif.funct3 = f3; fif.fm = fmv; fif.pred = pv; fif.succ = sv;
        for (int c = 1; c <= MAXC && o.lat < 0; c++) begin
            @(posedge clk); #1;
            fif.req_valid    = 1'($urandom);
            fif.funct3       = 3'($urandom);
            fif.fm           = 4'($urandom);
            fif.pred         = 4'($urandom);
            fif.succ         = 4'($urandom);
            fif.mem_pending  = mp[c];
            fif.sb_empty     = se[c];
            fif.ic_flush_ack = ak[c];
            #1;
            if (fif.sb_drain)     o.nsb++;
            if (fif.ic_flush_req) o.nicf++;
            if (fif.done_valid) begin
                o.lat  = c;
                o.kind = int'(fif.done_kind);
                o.pf   = int'(fif.pipe_flush);
                o.err  = int'(fif.timeout_err);
            end else if (fif.req_ready) begin
                o.rdy_bad++;
            end
        end
        set_idle();
        chk({nm, "_busy_ready"}, o.rdy_bad, 0);
    endtask

    function automatic fence_kind_t ref_kind(logic [2:0] f3, logic [3:0] fmv, logic [3:0] p, logic [3:0] s);
        if (f3 == 3'd1)                                return fk_fence_i;
        if (f3 != 3'd0)                                return fk_invalid;
        if (fmv == 4'd8 && p == 4'd3 && s == 4'd3)     return fk_fence_tso;
        if (p == 4'd0 || s == 4'd0)                    return fk_nop;
        return fk_fence;
    endfunction

    // Expected outcome derived from the whole stimulus arrays at once
    task automatic model(input logic [2:0] f3, input logic [3:0] fmv, input logic [3:0] p,
                         input logic [3:0] s, output obs_t e);
        fence_kind_t k;
        logic [NP-1:0] pm;
        bit wsb, to;
        int dend, st, iend;
        e = '{default: 0};
        k = ref_kind(f3, fmv, p, s);
        e.kind = int'(k);
        e.pf = (k == fk_fence_i) ? 1 : 0;
        if (k == fk_nop || k == fk_invalid) begin
            e.lat = 1; e.err = int'(mdl_err);
            return;
        end
        for (int i = 0; i < NP; i++)
            pm[i] = (k == fk_fence_i) ? 1'b1 : (IOM[i] ? (p[3] | p[2]) : (p[1] | p[0]));
        wsb = (k == fk_fence_i) || (k == fk_fence && p[0]);
        dend = 0; to = 0;
        for (int c = 1; c <= TMO && dend == 0; c++)
            if ((mp[c] & pm) == '0 && (se[c] || !wsb)) dend = c;
        if (dend == 0) begin dend = TMO; to = 1; end
        for (int c = 1; c <= dend; c++)
            if (wsb && !se[c]) e.nsb++;
        iend = dend;
        if (k == fk_fence_i && !to) begin
            st = dend + 1; iend = 0;
            for (int c = st; c < st + TMO && iend == 0; c++)
                if (ak[c]) iend = c;
            if (iend == 0) begin iend = st + TMO - 1; to = 1; end
            e.nicf = iend - st + 1;
        end
        e.lat = iend + 1;
        mdl_err = mdl_err | to;
        e.err = int'(mdl_err);
    endtask

    task automatic cmp(input string nm, input obs_t a, input obs_t e);
        chk({nm, "_lat"},  a.lat,  e.lat);
        chk({nm, "_kind"}, a.kind, e.kind);
        chk({nm, "_sbd"},  a.nsb,  e.nsb);
        chk({nm, "_icf"},  a.nicf, e.nicf);
        chk({nm, "_pf"},   a.pf,   e.pf);
        chk({nm, "_err"},  a.err,  e.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o, e;
        logic [2:0] f3; logic [3:0] fmv, pv, sv;
        int seen;

        //             f3      fm      pred    succ    mpv  mpn sbn ack kind          lat nsb icf pf err
        tbl[0]  = '{3'b000, 4'b0000, 4'b1111, 4'b1111, 2'b01, 3,  2,  0, fk_fence,     5, 2, 0, 0, 0};
        tbl[1]  = '{3'b000, 4'b1000, 4'b0011, 4'b0011, 2'b00, 0, 99,  0, fk_fence_tso, 2, 0, 0, 0, 0};
        tbl[2]  = '{3'b001, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0,  0,  5, fk_fence_i,   6, 0, 4, 1, 0};
        tbl[3]  = '{3'b010, 4'b0000, 4'b1111, 4'b1111, 2'b11, 99, 99, 0, fk_invalid,   1, 0, 0, 0, 0};
        tbl[4]  = '{3'b011, 4'b0000, 4'b1111, 4'b1111, 2'b11, 99, 99, 0, fk_invalid,   1, 0, 0, 0, 0};
        tbl[5]  = '{3'b100, 4'b1000, 4'b0011, 4'b0011, 2'b11, 99, 99, 0, fk_invalid,   1, 0, 0, 0, 0};
        tbl[6]  = '{3'b101, 4'b0000, 4'b1111, 4'b1111, 2'b11, 99, 99, 0, fk_invalid,   1, 0, 0, 0, 0};
        tbl[7]  = '{3'b110, 4'b0000, 4'b1111, 4'b1111, 2'b11, 99, 99, 0, fk_invalid,   1, 0, 0, 0, 0};
        tbl[8]  = '{3'b111, 4'b0000, 4'b1111, 4'b1111, 2'b11, 99, 99, 0, fk_invalid,   1, 0, 0, 0, 0};
        tbl[9]  = '{3'b000, 4'b0000, 4'b0000, 4'b1111, 2'b11, 99, 99, 0, fk_nop,       1, 0, 0, 0, 0};
        tbl[10] = '{3'b000, 4'b0000, 4'b1111, 4'b0000, 2'b11, 99, 99, 0, fk_nop,       1, 0, 0, 0, 0};
        tbl[11] = '{3'b000, 4'b0101, 4'b0010, 4'b0001, 2'b01, 2, 99,  0, fk_fence,     4, 0, 0, 0, 0};
        tbl[12] = '{3'b000, 4'b0000, 4'b0100, 4'b0010, 2'b01, 99, 99, 0, fk_fence,     2, 0, 0, 0, 0};
        tbl[13] = '{3'b001, 4'b0000, 4'b0000, 4'b0000, 2'b11, 2,  3,  5, fk_fence_i,   6, 3, 1, 1, 0};
        tbl[14] = '{3'b000, 4'b0000, 4'b1000, 4'b1111, 2'b10, 7, 99,  0, fk_fence,     9, 0, 0, 0, 0};
        tbl[15] = '{3'b000, 4'b0000, 4'b1000, 4'b1111, 2'b10, 99, 99, 0, fk_fence,     9, 0, 0, 0, 1};
        tbl[16] = '{3'b001, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0,  0,  0, fk_fence_i,  10, 0, 8, 1, 1};
        tbl[17] = '{3'b001, 4'b0000, 4'b0000, 4'b0000, 2'b10, 99, 0,  0, fk_fence_i,   9, 0, 0, 1, 1};

        set_idle();
        fif.funct3 = '0; fif.fm = '0; fif.pred = '0; fif.succ = '0;
        #1;
        chk("rst_ready",  int'(fif.req_ready),    1);
        chk("rst_done",   int'(fif.done_valid),   0);
        chk("rst_sbd",    int'(fif.sb_drain),     0);
        chk("rst_icf",    int'(fif.ic_flush_req), 0);
        chk("rst_pf",     int'(fif.pipe_flush),   0);
        chk("rst_err",    int'(fif.timeout_err),  0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            fill(tbl[i].mpv, tbl[i].mpn, tbl[i].sbn, tbl[i].ackc);
            run($sformatf("vec%0d", i), tbl[i].f3, tbl[i].fm, tbl[i].pred, tbl[i].succ, o);
            e = '{lat: tbl[i].lat, nsb: tbl[i].nsb, nicf: tbl[i].nicf, kind: int'(tbl[i].kind),
                  pf: tbl[i].pf, err: tbl[i].err, rdy_bad: 0};
            cmp($sformatf("vec%0d", i), o, e);
        end

        // Async reset in the middle of an I-cache flush aborts with no completion
        fill(2'b00, 0, 0, 0);
        @(posedge clk); #1;
        fif.req_valid = 1'b1; fif.funct3 = 3'b001;
        @(posedge clk); #1;
        fif.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("ar_icf_before", int'(fif.ic_flush_req), 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_icf",   int'(fif.ic_flush_req), 0);
        chk("ar_ready", int'(fif.req_ready),    1);
        chk("ar_err",   int'(fif.timeout_err),  0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (fif.done_valid) seen++;
        end
        chk("ar_no_done", seen, 0);
        rst = 1'b1;
        mdl_err = 0;

        for (int n = 0; n < 60; n++) begin
            int r, mpn, sbn;
            r   = $urandom_range(0, 9);
            f3  = (r < 5) ? 3'b000 : (r < 8) ? 3'b001 : 3'($urandom_range(2, 7));
            fmv = ($urandom_range(0, 1) == 0) ? 4'b1000 : 4'($urandom);
            pv  = 4'($urandom);
            sv  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin fmv = 4'b1000; pv = 4'b0011; sv = 4'b0011; end
            mpn = $urandom_range(0, 10);
            sbn = $urandom_range(0, 10);
            for (int c = 0; c <= MAXC; c++) begin
                mp[c] = (c <= mpn) ? 2'($urandom) : 2'b00;
                se[c] = (c > sbn) ? 1'b1 : ($urandom_range(0, 3) == 0);
                ak[c] = ($urandom_range(0, 3) == 0);
            end
            model(f3, fmv, pv, sv, e);
            run($sformatf("rnd%0d", n), f3, fmv, pv, sv, o);
            cmp($sformatf("rnd%0d", n), o, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
